sum_acc: RTL and testbench

Parametrised, handshaked accumulating adder. It is the sequential successor of the team's two-operand combinational adder. It sums a variable-length group of DATA_W-bit unsigned operands arriving one per cycle and returns the group sum, the operand count and an overflow flag. It sits between a valid/ready operand source and a valid/ready result sink. With MAX_OPS=2 and SAT=0 it reproduces the 2-bit + 2-bit -> 3-bit behaviour, registered.

---
 rtl/sum_acc_pkg.sv | 22 ++
 rtl/sum_acc_if.sv | 34 +++
 rtl/sum_acc_add_sat.sv | 22 ++
 rtl/sum_acc.sv | 92 +++++++++
 tb/tb_sum_acc.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/sum_acc_pkg.sv
// Shared constants and helpers for the sum_acc accumulating adder.
package sum_acc_pkg;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

  localparam int unsigned SAT_WRAP  = 0;
  localparam int unsigned SAT_CLAMP = 1;

endpackage

// File: rtl/sum_acc_if.sv
// Operand (source side) and result (sink side) handshake bundle for sum_acc.
interface sum_acc_if
  import sum_acc_pkg::*;
#(
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned MAX_OPS = 4
) ();

  localparam int unsigned ACC_W = DATA_W + clog2(MAX_OPS);
  localparam int unsigned CNT_W = clog2(MAX_OPS + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Environment side: drives operands and result acceptance.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/sum_acc_add_sat.sv
// add_sat: combinational accumulator adder with carry-out and optional clamp.
module sum_acc_add_sat
  import sum_acc_pkg::*;
#(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned ACC_W  = 4,
  parameter int unsigned SAT    = SAT_WRAP
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [DATA_W-1:0] i_op,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, i_op};
  assign o_carry = w_full[ACC_W];
  // Clamped accumulator stays at all-ones: any further nonzero add carries again.
  assign o_sum   = ((SAT == SAT_CLAMP) && w_full[ACC_W]) ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/sum_acc.sv
// sum_acc: sums a variable-length group of operands and returns sum, count and overflow.
module sum_acc
  import sum_acc_pkg::*;
#(
  parameter int unsigned DATA_W  = 2,
  parameter int unsigned MAX_OPS = 4,
  parameter int unsigned SAT     = SAT_WRAP
) (
  input logic      clk,
  input logic      rst,
  sum_acc_if.slave bus
);

  localparam int unsigned ACC_W = DATA_W + clog2(MAX_OPS);
  localparam int unsigned CNT_W = clog2(MAX_OPS + 1);

  state_e           r_state;
  state_e           w_state_d;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_out_ovf;

  logic             w_accept;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_carry;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ovf_nxt;

  sum_acc_add_sat #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SAT    (SAT)
  ) u_add_sat (
    .i_acc   (r_acc),
    .i_op    (bus.in_data),
    .o_sum   (w_acc_nxt),
    .o_carry (w_carry)
  );

  // Reset masks in_ready so nothing is offered as accepted while rst is held.
  assign bus.in_ready  = (r_state == ST_ACC) & ~rst;
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_sum   = r_sum;
  assign bus.out_count = r_count;
  assign bus.out_ovf   = r_out_ovf;

  assign w_accept  = bus.in_valid & bus.in_ready;
  assign w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_ovf_nxt = r_ovf | w_carry;

  // Next-state decode: close a group on last accept, release on sink acceptance.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_ACC:  if (w_accept && bus.in_last) w_state_d = ST_DONE;
      ST_DONE: if (bus.out_ready)           w_state_d = ST_ACC;
    endcase
  end

  // State, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ACC;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_sum     <= '0;
      r_count   <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == ST_ACC) && w_accept) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
        r_ovf <= w_ovf_nxt;
        if (bus.in_last) begin
          r_sum     <= w_acc_nxt;
          r_count   <= w_cnt_nxt;
          r_out_ovf <= w_ovf_nxt;
        end
      end else if ((r_state == ST_DONE) && bus.out_ready) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sum_acc.sv
// Self-checking bench for sum_acc: wrap (SAT=0) and clamp (SAT=1) instances share stimulus.
module tb_sum_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_last;
  logic       out_ready;

  int total = 0;
  int bad   = 0;

  sum_acc_if #(.DATA_W(2), .MAX_OPS(4)) bus_w ();
  sum_acc_if #(.DATA_W(2), .MAX_OPS(4)) bus_s ();

  assign bus_w.in_valid  = in_valid;
  assign bus_w.in_data   = in_data;
  assign bus_w.in_last   = in_last;
  assign bus_w.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.in_last   = in_last;
  assign bus_s.out_ready = out_ready;

  sum_acc #(.DATA_W(2), .MAX_OPS(4), .SAT(0)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  sum_acc #(.DATA_W(2), .MAX_OPS(4), .SAT(1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;   // expected sum, wrap instance
    logic [3:0] ss;   // expected sum, clamp instance
    logic [2:0] cnt;
    logic       ovf;
  } exp_t;

  typedef struct {
    int          n;     // operands in group
    logic [15:0] ops;   // operand k at ops[2k +: 2]
    int          gap;   // idle cycles before each operand after the first
    int          hold;  // cycles of out_ready=0 before taking the result
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Result monitor: every cycle a result is held it must match the scoreboard head.
  always @(negedge clk) begin
    if (bus_w.out_valid || bus_s.out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got out_valid=1 expected no pending result at %0t", $time);
      end else begin
        mon_e = sb[0];
        check("valid_pair", 32'(bus_s.out_valid), 32'(bus_w.out_valid));
        check("sum_wrap",   32'(bus_w.out_sum),   32'(mon_e.sw));
        check("sum_clamp",  32'(bus_s.out_sum),   32'(mon_e.ss));
        check("count_wrap", 32'(bus_w.out_count), 32'(mon_e.cnt));
        check("count_clamp", 32'(bus_s.out_count), 32'(mon_e.cnt));
        check("ovf_wrap",   32'(bus_w.out_ovf),   32'(mon_e.ovf));
        check("ovf_clamp",  32'(bus_s.out_ovf),   32'(mon_e.ovf));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand after `gap` idle cycles of garbage data; returns just after its accept.
  task automatic send(input logic [1:0] d, input logic last, input int gap);
    int b;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = 2'd3;
      in_last  = 1'b1;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    b = 0;
    while (!bus_w.in_ready && b < 20) begin
      tick();
      b++;
    end
    if (b == 20) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 2'd3;
    in_last  = 1'b1;
  endtask

  // Called right after the last accept: check latency, backpressure and turnaround.
  task automatic collect(input int hold);
    check("valid_latency", 32'(bus_w.out_valid), 32'd1);
    check("ready_in_done", 32'(bus_w.in_ready), 32'd0);
    repeat (hold) begin
      tick();
      check("bp_valid", 32'(bus_w.out_valid), 32'd1);
      check("bp_ready", 32'(bus_w.in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("turn_valid", 32'(bus_w.out_valid), 32'd0);
    check("turn_ready", 32'(bus_w.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    //           n  ops        gap hold  sw     ss     cnt   ovf
    vt[0] = '{4, 16'h00FF, 0, 0, '{4'd12, 4'd12, 3'd4, 1'b0}};  // 3,3,3,3
    vt[1] = '{2, 16'h0009, 0, 5, '{4'd3,  4'd3,  3'd2, 1'b0}};  // 1,2 held 5 cycles
    vt[2] = '{1, 16'h0002, 0, 0, '{4'd2,  4'd2,  3'd1, 1'b0}};  // 2
    vt[3] = '{6, 16'h0FFF, 0, 1, '{4'd2,  4'd15, 3'd6, 1'b1}};  // six 3s
    vt[4] = '{2, 16'h0009, 3, 0, '{4'd3,  4'd3,  3'd2, 1'b0}};  // 1,2 gapped
    vt[5] = '{8, 16'hFFFF, 0, 0, '{4'd8,  4'd15, 3'd7, 1'b1}};  // eight 3s, count saturates
    vt[6] = '{1, 16'h0000, 0, 0, '{4'd0,  4'd0,  3'd1, 1'b0}};  // 0
    vt[7] = '{5, 16'h03FF, 0, 0, '{4'd15, 4'd15, 3'd5, 1'b0}};  // reaches all-ones, no carry
    vt[8] = '{6, 16'h07FF, 1, 2, '{4'd0,  4'd15, 3'd6, 1'b1}};  // 3x5 then 1 -> 16

    // Reset held two cycles with a valid operand presented.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 2'd3;
    in_last   = 1'b1;
    out_ready = 1'b0;
    repeat (2) begin
      tick();
      check("rst_in_ready",  32'(bus_w.in_ready),  32'd0);
      check("rst_out_valid", 32'(bus_w.out_valid), 32'd0);
      check("rst_out_sum",   32'(bus_w.out_sum),   32'd0);
      check("rst_out_count", 32'(bus_w.out_count), 32'd0);
      check("rst_out_ovf",   32'(bus_w.out_ovf),   32'd0);
      check("rst_sum_clamp", 32'(bus_s.out_sum),   32'd0);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus_w.in_ready), 32'd1);
    check("post_rst_valid", 32'(bus_w.out_valid), 32'd0);

    // Table-driven groups.
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vt[i].n; k++) begin
        send(vt[i].ops[2*k +: 2], (k == vt[i].n - 1), (k == 0) ? 0 : vt[i].gap);
      end
      sb.push_back(vt[i].e);
      collect(vt[i].hold);
    end

    // Reset mid-group discards the partial sum.
    send(2'd3, 1'b0, 0);
    send(2'd2, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus_w.in_ready), 32'd1);
    send(2'd1, 1'b1, 0);
    sb.push_back('{4'd1, 4'd1, 3'd1, 1'b0});
    collect(0);

    // Reset while a result is pending drops it without a transfer.
    send(2'd2, 1'b1, 0);
    sb.push_back('{4'd2, 4'd2, 3'd1, 1'b0});
    check("done_valid", 32'(bus_w.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    #1;
    check("donerst_valid", 32'(bus_w.out_valid), 32'd0);
    check("donerst_ready", 32'(bus_w.in_ready), 32'd1);
    send(2'd1, 1'b0, 0);
    send(2'd1, 1'b1, 0);
    sb.push_back('{4'd2, 4'd2, 3'd2, 1'b0});
    collect(1);

    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
